// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_operand_sequencer                                                    |
// | Walks an M x N output tile and streams K_LEN-term operand pairs into the |
// | MAC lane. B_COL_MAJOR_EN selects a column-major B buffer layout.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mac_operand_sequencer #(
    parameter int M         = 4,
    parameter int N         = 4,
    parameter int K_LEN     = 8,
    parameter int A_AW      = 5,
    parameter int B_AW      = 5,
    parameter int DRAIN_CYC = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic                                 start_i,
    input  logic                                 stall_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [A_AW-1:0]                      a_addr_o,
    output logic                                 a_rd_o,
    input  logic [7:0]                           a_data_i,
    output logic [B_AW-1:0]                      b_addr_o,
    output logic                                 b_rd_o,
    input  logic [7:0]                           b_data_i,
    output logic [7:0]                           dsp_input_o,
    output logic [7:0]                           dsp_weight_o,
    output logic                                 dsp_enable_o,
    output logic                                 clear_o,
    output logic                                 dsp_valid_o,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_col_o
);

    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam int DW = $clog2(DRAIN_CYC + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   m_cnt;
    logic [CW-1:0]   n_cnt;
    logic [KW-1:0]   k_cnt;
    logic [DW-1:0]   drain_cnt;

    logic            k_last;
    logic            n_last;
    logic            m_last;
    logic            issue;
    logic            frozen;
    logic            drain_done;

    logic            live_q;
    logic            clr_q;
    logic            val_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;

    assign k_last     = (k_cnt == KW'(K_LEN - 1));
    assign n_last     = (n_cnt == CW'(N - 1));
    assign m_last     = (m_cnt == RW'(M - 1));
    assign issue      = (state == STREAM) && !stall_i;
    // Stall only matters while a beat can be in flight.
    assign frozen     = stall_i && ((state == STREAM) || (state == DRAIN));
    assign drain_done = (state == DRAIN) && !stall_i && (drain_cnt == DW'(DRAIN_CYC));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        a_rd_o    = 1'b0;
        b_rd_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                busy_o = 1'b1;
                a_rd_o = !stall_i;
                b_rd_o = !stall_i;
                if (issue && k_last && n_last && m_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (drain_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Loop nest: k innermost, then n, then m; wraps cost no bubble.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_cnt <= '0;
            n_cnt <= '0;
            k_cnt <= '0;
        end else if (state != STREAM) begin
            m_cnt <= '0;
            n_cnt <= '0;
            k_cnt <= '0;
        end else if (issue) begin
            if (!k_last) begin
                k_cnt <= k_cnt + KW'(1);
            end else begin
                k_cnt <= '0;
                if (!n_last) begin
                    n_cnt <= n_cnt + CW'(1);
                end else begin
                    n_cnt <= '0;
                    m_cnt <= m_last ? '0 : m_cnt + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            drain_cnt <= '0;
        end else if (state != DRAIN) begin
            drain_cnt <= '0;
        end else if (!stall_i) begin
            drain_cnt <= drain_cnt + DW'(1);
        end
    end

    // One-stage strobe/tag pipe lines up with the registered buffer data.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            live_q <= 1'b0;
            clr_q  <= 1'b0;
            val_q  <= 1'b0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (!frozen) begin
            live_q <= issue;
            clr_q  <= issue && (k_cnt == '0);
            val_q  <= issue && k_last;
            row_q  <= m_cnt;
            col_q  <= n_cnt;
        end
    end

    assign a_addr_o = A_AW'(32'(m_cnt) * 32'(K_LEN) + 32'(k_cnt));
`ifdef B_COL_MAJOR_EN
    assign b_addr_o = B_AW'(32'(n_cnt) * 32'(K_LEN) + 32'(k_cnt));
`else
    assign b_addr_o = B_AW'(32'(k_cnt) * 32'(N) + 32'(n_cnt));
`endif

    assign dsp_input_o  = a_data_i;
    assign dsp_weight_o = b_data_i;
    assign dsp_enable_o = live_q && !frozen;
    assign clear_o      = clr_q && !frozen;
    assign dsp_valid_o  = val_q && !frozen;
    assign out_row_o    = row_q;
    assign out_col_o    = col_q;

endmodule
`default_nettype wire
